// File: rtl/fft_frame_sequencer.sv
// Frame driver/collector in front of an FFT core: buffers one real-input frame, streams it out,
// captures N complex results and supervises the frame with a cycle timeout.
module fft_frame_sequencer #(
    parameter int N       = 32,
    parameter int IN_W    = 8,
    parameter int OUT_W   = 18,
    parameter int TIMEOUT = 150,
    parameter int AW      = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [IN_W-1:0]  wr_data,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [AW:0]      out_cnt,
    output logic             fft_valid_o,
    output logic [IN_W-1:0]  fft_x_r_o,
    input  logic             fft_finish_i,
    input  logic [OUT_W-1:0] fft_X_r_i,
    input  logic [OUT_W-1:0] fft_X_i_i,
    input  logic [AW-1:0]    rd_addr,
    output logic [OUT_W-1:0] rd_data_r,
    output logic [OUT_W-1:0] rd_data_i
);

    localparam int CW     = $clog2(TIMEOUT + 1);
    localparam int LP_NM1 = N - 1;
    localparam int LP_TM1 = TIMEOUT - 1;
    localparam logic [AW:0]   LP_CNT_N    = N[AW:0];
    localparam logic [AW:0]   LP_CNT_LAST = LP_NM1[AW:0];
    localparam logic [AW-1:0] LP_IDX_LAST = LP_NM1[AW-1:0];
    localparam logic [CW-1:0] LP_CYC_LAST = LP_TM1[CW-1:0];

    typedef enum logic [1:0] {S_IDLE, S_FEED, S_WAIT} state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [IN_W-1:0]  r_in_buf [N];
    logic [OUT_W-1:0] r_res_r  [N];
    logic [OUT_W-1:0] r_res_i  [N];

    logic [AW-1:0]   r_idx;
    logic [CW-1:0]   r_cyc;
    logic [AW:0]     r_out_cnt;
    logic            r_done;
    logic            r_timeout;
    logic            r_valid;
    logic [IN_W-1:0] r_x;

    logic            w_busy;
    logic            w_start;
    logic            w_cap;
    logic            w_last_cap;
    logic            w_full;
    logic            w_tmo;
    logic            w_feed_last;
    logic [AW-1:0]   w_idx_inc;
    logic [IN_W-1:0] w_first;

    assign w_busy      = (r_state != S_IDLE);
    assign w_start     = (r_state == S_IDLE) && start;
    assign w_cap       = w_busy && fft_finish_i && (r_out_cnt != LP_CNT_N);
    assign w_last_cap  = w_cap && (r_out_cnt == LP_CNT_LAST);
    assign w_full      = w_last_cap || (r_out_cnt == LP_CNT_N);
    // r_cyc counts completed busy cycles, so the current cycle's count is r_cyc + 1
    assign w_tmo       = w_busy && !w_full && (r_cyc == LP_CYC_LAST);
    assign w_feed_last = (r_state == S_FEED) && (r_idx == LP_IDX_LAST);
    assign w_idx_inc   = r_idx + 1'b1;
    // A write to address 0 in the start cycle must reach the first fed sample
    assign w_first     = (wr_en && (wr_addr == '0)) ? wr_data : r_in_buf[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (start) w_state_nxt = S_FEED;
            S_FEED: begin
                if (w_tmo) begin
                    w_state_nxt = S_IDLE;
                end else if (w_feed_last) begin
                    w_state_nxt = w_full ? S_IDLE : S_WAIT;
                end
            end
            S_WAIT: if (w_full || w_tmo) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_x       <= '0;
            r_idx     <= '0;
            r_cyc     <= '0;
            r_out_cnt <= '0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else if (w_start) begin
            r_valid   <= 1'b1;
            r_x       <= w_first;
            r_idx     <= '0;
            r_cyc     <= '0;
            r_out_cnt <= '0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else if (w_busy) begin
            if (r_cyc != '1) r_cyc <= r_cyc + 1'b1;
            if (w_cap) r_out_cnt <= r_out_cnt + 1'b1;
            if (w_last_cap) r_done <= 1'b1;
            if (w_tmo) r_timeout <= 1'b1;
            if (w_state_nxt == S_FEED) begin
                r_idx <= w_idx_inc;
                r_x   <= r_in_buf[w_idx_inc];
            end else begin
                r_valid <= 1'b0;
                r_x     <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if ((r_state == S_IDLE) && wr_en) r_in_buf[wr_addr] <= wr_data;
        if (w_cap) begin
            r_res_r[r_out_cnt[AW-1:0]] <= fft_X_r_i;
            r_res_i[r_out_cnt[AW-1:0]] <= fft_X_i_i;
        end
    end

    assign busy        = w_busy;
    assign done        = r_done;
    assign timeout     = r_timeout;
    assign out_cnt     = r_out_cnt;
    assign fft_valid_o = r_valid;
    assign fft_x_r_o   = r_x;
    assign rd_data_r   = r_res_r[rd_addr];
    assign rd_data_i   = r_res_i[rd_addr];

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer: default 32-point instance driven from a vector table,
// plus hand sequences for in-frame reset, idle finish pulses and a 16-point instance.
module tb_fft_frame_sequencer;

    localparam int N  = 32;
    localparam int IW = 8;
    localparam int OW = 18;
    localparam int AW = 5;

    localparam int N16  = 16;
    localparam int IW16 = 12;
    localparam int OW16 = 20;
    localparam int AW16 = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          wr_en, start, fin, busy, done, tmo, valid;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [IW-1:0] wr_data, x;
    logic [OW-1:0] xr, xi, rdr, rdi;
    logic [AW:0]   out_cnt;

    logic            wr_en16, start16, fin16, busy16, done16, tmo16, valid16;
    logic [AW16-1:0] wr_addr16, rd_addr16;
    logic [IW16-1:0] wr_data16, x16;
    logic [OW16-1:0] xr16, xi16, rdr16, rdi16;
    logic [AW16:0]   out_cnt16;

    fft_frame_sequencer u_dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .busy(busy), .done(done), .timeout(tmo), .out_cnt(out_cnt),
        .fft_valid_o(valid), .fft_x_r_o(x), .fft_finish_i(fin), .fft_X_r_i(xr),
        .fft_X_i_i(xi), .rd_addr(rd_addr), .rd_data_r(rdr), .rd_data_i(rdi)
    );

    fft_frame_sequencer #(.N(N16), .IN_W(IW16), .OUT_W(OW16), .TIMEOUT(80)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en16), .wr_addr(wr_addr16), .wr_data(wr_data16),
        .start(start16), .busy(busy16), .done(done16), .timeout(tmo16), .out_cnt(out_cnt16),
        .fft_valid_o(valid16), .fft_x_r_o(x16), .fft_finish_i(fin16), .fft_X_r_i(xr16),
        .fft_X_i_i(xi16), .rd_addr(rd_addr16), .rd_data_r(rdr16), .rd_data_i(rdi16)
    );

    typedef struct {
        int seed;
        bit reload;
        int fin_start;
        int fin_step;
        int fin_num;
        int inj;
        int exp_fall;
        bit exp_done;
        bit exp_tmo;
        int exp_cnt;
    } vec_t;

    vec_t vecs[8];
    logic [IW-1:0]   in_model[N];
    logic [IW16-1:0] in16[N16];
    int checks = 0;
    int errors = 0;

    function automatic int mk_r(input int k, input int seed);
        return k * 1013 + seed * 7 + 5;
    endfunction

    function automatic int mk_i(input int k, input int seed);
        return 32'h3FF00 - k * 211 - seed;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_frame(input vec_t v, input int id);
        int c, k, nv, bad, fall;
        if (v.reload) begin
            for (int i = 0; i < N; i++) in_model[i] = IW'(i + v.seed * 5);
            for (int i = N - 1; i >= 1; i--) begin
                wr_en = 1'b1; wr_addr = AW'(i); wr_data = in_model[i];
                @(posedge clk); #1;
            end
            wr_addr = '0; wr_data = in_model[0];
        end
        wr_en = v.reload;
        start = 1'b1;
        @(posedge clk); #1;
        wr_en = 1'b0; start = 1'b0;
        c = 1; k = 0; nv = 0; bad = 0; fall = -1;
        while (c <= 400 && fall < 0) begin
            if (!busy) begin
                fall = c;
            end else begin
                if (valid !== (c <= N)) bad++;
                if (valid) begin
                    if (nv < N && x !== in_model[nv]) bad++;
                    nv++;
                end else if (x !== '0) begin
                    bad++;
                end
                if (k < v.fin_num && c >= v.fin_start && ((c - v.fin_start) % v.fin_step) == 0) begin
                    fin = 1'b1; xr = OW'(mk_r(k, v.seed)); xi = OW'(mk_i(k, v.seed)); k++;
                end else begin
                    fin = 1'b0; xr = '1; xi = '1;
                end
                if (c == v.inj) begin
                    start = 1'b1; wr_en = 1'b1; wr_addr = AW'(3); wr_data = 8'hFF;
                end else begin
                    start = 1'b0; wr_en = 1'b0;
                end
                @(posedge clk); #1;
                c++;
            end
        end
        fin = 1'b0; start = 1'b0; wr_en = 1'b0;
        check($sformatf("v%0d feed_errs", id), bad, 0);
        check($sformatf("v%0d valid_cycles", id), nv, N);
        check($sformatf("v%0d busy_fall_cycle", id), fall, v.exp_fall);
        check($sformatf("v%0d done", id), done, v.exp_done);
        check($sformatf("v%0d timeout", id), tmo, v.exp_tmo);
        check($sformatf("v%0d out_cnt", id), out_cnt, v.exp_cnt);
        bad = 0;
        for (int j = 0; j < v.exp_cnt; j++) begin
            rd_addr = AW'(j); #1;
            if (rdr !== OW'(mk_r(j, v.seed)) || rdi !== OW'(mk_i(j, v.seed))) bad++;
        end
        check($sformatf("v%0d readback_errs", id), bad, 0);
    endtask

    task automatic run16(input int fin_num, input int exp_fall, input int exp_done,
                         input int exp_tmo, input int exp_cnt);
        int c, k, nv, bad, fall;
        for (int i = 0; i < N16; i++) begin
            in16[i] = IW16'(i * 173 + fin_num + 12'h800);
            wr_en16 = 1'b1; wr_addr16 = AW16'(i); wr_data16 = in16[i];
            @(posedge clk); #1;
        end
        wr_en16 = 1'b0; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        c = 1; k = 0; nv = 0; bad = 0; fall = -1;
        while (c <= 300 && fall < 0) begin
            if (!busy16) begin
                fall = c;
            end else begin
                if (valid16 !== (c <= N16)) bad++;
                if (valid16) begin
                    if (nv < N16 && x16 !== in16[nv]) bad++;
                    nv++;
                end else if (x16 !== '0) begin
                    bad++;
                end
                fin16 = (k < fin_num && c >= 20);
                xr16 = OW16'(mk_r(k, 9)); xi16 = OW16'(mk_i(k, 9));
                if (fin16) k++;
                @(posedge clk); #1;
                c++;
            end
        end
        // keep finish high a few idle cycles: the count must not move past N
        fin16 = 1'b1;
        repeat (3) @(posedge clk);
        #1 fin16 = 1'b0;
        check("n16 feed_errs", bad, 0);
        check("n16 valid_cycles", nv, N16);
        check("n16 busy_fall_cycle", fall, exp_fall);
        check("n16 done", done16, exp_done);
        check("n16 timeout", tmo16, exp_tmo);
        check("n16 out_cnt", out_cnt16, exp_cnt);
        bad = 0;
        for (int j = 0; j < exp_cnt; j++) begin
            rd_addr16 = AW16'(j); #1;
            if (rdr16 !== OW16'(mk_r(j, 9)) || rdi16 !== OW16'(mk_i(j, 9))) bad++;
        end
        check("n16 readback_errs", bad, 0);
    endtask

    initial begin
        vecs[0] = '{0, 1, 41,  1, 32, -1, 73,  1, 0, 32};
        vecs[1] = '{1, 1, 1,   1, 0,  -1, 151, 0, 1, 0};
        vecs[2] = '{2, 1, 88,  2, 32, -1, 151, 1, 0, 32};
        vecs[3] = '{3, 1, 90,  2, 31, -1, 151, 0, 1, 31};
        vecs[4] = '{4, 1, 1,   1, 32, -1, 33,  1, 0, 32};
        vecs[5] = '{5, 1, 130, 1, 40, -1, 151, 0, 1, 21};
        vecs[6] = '{6, 1, 41,  1, 32, 5,  73,  1, 0, 32};
        vecs[7] = '{7, 0, 41,  1, 32, -1, 73,  1, 0, 32};

        wr_en = 0; start = 0; fin = 0; wr_addr = '0; wr_data = '0; xr = '0; xi = '0; rd_addr = '0;
        wr_en16 = 0; start16 = 0; fin16 = 0; wr_addr16 = '0; wr_data16 = '0;
        xr16 = '0; xi16 = '0; rd_addr16 = '0;

        #22;
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst timeout", tmo, 0);
        check("rst valid", valid, 0);
        check("rst x", x, 0);
        check("rst out_cnt", out_cnt, 0);
        check("rst16 busy", busy16, 0);
        check("rst16 valid", valid16, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) run_frame(vecs[i], i);

        // finish pulses while idle must not touch count or results
        fin = 1'b1; xr = '0; xi = '0;
        repeat (3) @(posedge clk);
        #1 fin = 1'b0;
        rd_addr = '0; #1;
        check("idle_fin out_cnt", out_cnt, 32);
        check("idle_fin res0_r", rdr, OW'(mk_r(0, 7)));

        // reset asserted in the 10th valid cycle acts without a clock edge
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c < 10; c++) begin
            @(posedge clk); #1;
        end
        check("midrst pre_valid", valid, 1);
        check("midrst pre_x", x, in_model[9]);
        #2 rst_n = 1'b0;
        #1;
        check("midrst valid", valid, 0);
        check("midrst busy", busy, 0);
        check("midrst x", x, 0);
        check("midrst out_cnt", out_cnt, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("postrst idle", busy, 0);
        run_frame(vecs[0], 8);

        run16(21, 36, 1, 0, 16);
        run16(0, 81, 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
